sa_tile_control: RTL and testbench
==================================

SA_TILE_CONTROL -- requirements
Module: sa_tile_control

Interface
REQ-001 SHALL have parameter NUM_ROWS, default 4: array rows; also weight rows per tile.
REQ-002 SHALL have parameter NUM_COLS, default 4: array columns.
REQ-003 SHALL have parameter INPUT_HEIGHT, default 64: input memory depth.
REQ-004 SHALL have parameter WEIGHT_HEIGHT, default 64: weight memory depth; must be >= MAX_TILES*NUM_ROWS.
REQ-005 SHALL have parameter OUTPUT_HEIGHT, default 64: output/psum memory depth.
REQ-006 SHALL have parameter MAX_TILES, default 4: maximum K-tiles per job.
REQ-007 SHALL use clock clk; reset rst_n, asynchronous, active-low.
REQ-008 SHALL have these ports (name, direction, width, meaning):
- clk, input, 1: clock.
- rst_n, input, 1: reset.
- i_start, input, 1: job request.
- i_num_tiles, input, $clog2(MAX_TILES+1): tile count T.
- i_stream_len, input, $clog2(INPUT_HEIGHT+1): input vectors L.
- o_busy, output, 1: job active.
- o_done, output, 1: one-cycle completion pulse.
- r_input_cenb / r_input_wenb / r_input_addr, output, 1 / 1 / $clog2(INPUT_HEIGHT): input memory read.
- r_weight_cenb / r_weight_wenb / r_weight_addr, output, 1 / 1 / $clog2(WEIGHT_HEIGHT): weight memory read.
- r_psum_cenb / r_psum_addr, output, 1 / $clog2(OUTPUT_HEIGHT): psum readback from output memory.
- w_output_cenb / w_output_wenb / w_output_addr, output, 1 / 1 / $clog2(OUTPUT_HEIGHT): output write.
- o_mode, output, 1: 0 preload, 1 compute.
- o_load_psum, output, 1: 1 means the array adds the psum-memory value; 0 means psum is zero.
- o_tile_idx, output, $clog2(MAX_TILES): current tile.

Function
REQ-009 SHALL implement states IDLE, PRELOAD, STREAM, DONE; any illegal state SHALL drive all outputs X and return to IDLE.
REQ-010 In IDLE, SHALL accept i_start only if i_num_tiles!=0 and i_stream_len!=0; otherwise i_start is ignored.
REQ-011 On an accepted start, SHALL latch T and L:
- T saturates to MAX_TILES.
- L saturates to min(INPUT_HEIGHT, OUTPUT_HEIGHT).
- tile index and count clear to 0.
- next state is PRELOAD.
REQ-012 SHALL ignore i_start while in PRELOAD, STREAM or DONE.
REQ-013 PRELOAD SHALL last NUM_ROWS cycles.
- Weight reads at addresses t*NUM_ROWS+k, k=0..NUM_ROWS-1.
- o_mode=0.
- Then go to STREAM with count cleared.
REQ-014 STREAM SHALL last L+LAT cycles, where LAT=NUM_ROWS+NUM_COLS.
- Input reads addr 0..L-1 during count 0..L-1.
- Output writes (wenb=0) addr 0..L-1 during count LAT..LAT+L-1.
- o_mode=1.
REQ-015 For tile t>0:
- Psum read of addr j SHALL issue at count LAT-1+j, i.e. one cycle before write j.
- o_load_psum=1 throughout STREAM.
For tile 0: no psum reads, and o_load_psum=0.
REQ-016 At the end of STREAM, SHALL go to PRELOAD of tile t+1 if t+1<T, else to DONE.
REQ-017 DONE SHALL last one cycle, pulse o_done=1, then return to IDLE.
REQ-018 o_busy SHALL be 1 in PRELOAD, STREAM and DONE.
REQ-019 All memory, mode and psum outputs SHALL be registered, appearing the cycle after the state/count requesting them.
REQ-020 Unused cenb outputs SHALL be 1, wenb outputs 1, and addresses 0.
REQ-021 The total busy cycles SHALL equal T*(NUM_ROWS+L+LAT)+1.

Reset
REQ-022 On rst_n low, SHALL asynchronously set:
- state IDLE; counters and tile index 0.
- all cenb=1, all wenb=1, all addresses 0.
- o_mode=0, o_load_psum=0, o_busy=0, o_done=0, o_tile_idx=0.
REQ-023 Reset asserted mid-job SHALL abort the job with no o_done pulse; after release, a new start SHALL behave per REQ-010.

Configuration
REQ-024 With SA_PERF_CNT_EN defined, SHALL add output o_cycle_count[31:0]:
- cleared on accepted start.
- increments each busy cycle.
- holds after DONE; saturates at all-ones.
REQ-025 Without SA_PERF_CNT_EN, the port and its counter SHALL be absent; all other behaviour is identical.

Structure
REQ-026 sa_pkg SHALL hold the enum sa_ctrl_state_e (IDLE, PRELOAD, STREAM, DONE, STATEX) and the LAT derivation function.
REQ-027 SHALL instantiate sub-module sa_addr_gen (clear/enable counter with wrap to 0 at a parameterised limit) once for each of the input, weight, psum and output address streams.

Verification (NUM_ROWS=NUM_COLS=4, LAT=8)
REQ-028 Reset check: after reset, all cenb=1, o_busy=0, o_done=0, o_mode=0.
REQ-029 T=1, L=4 check:
- weight addresses 0..3, then input addresses 0..3.
- writes 0..3 starting 8 cycles after the first input read.
- o_load_psum stays 0; one o_done pulse; 17 busy cycles.
REQ-030 T=3, L=2 check:
- weight addresses 0-3, 4-7, 8-11.
- psum reads and o_load_psum=1 only for tiles 1 and 2; o_tile_idx steps 0,1,2.
- 43 busy cycles.
REQ-031 Ignored-start check: i_start with T=0, with L=0, or during STREAM gives no state change and no extra o_done.
REQ-032 Reset mid-STREAM of tile 1 gives immediate idle outputs and no o_done; a subsequent T=1, L=1 job completes in 14 busy cycles.
REQ-033 With SA_PERF_CNT_EN, T=2, L=4 ends with o_cycle_count=33, held until the next start.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared types and helpers for the systolic-array tile controller.
package sa_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRELOAD = 3'd1,
    STREAM  = 3'd2,
    DONE    = 3'd3,
    STATEX  = 3'd7
  } sa_ctrl_state_e;

  // Cycles from an input vector entering the array to its result leaving it.
  function automatic int sa_lat(input int rows, input int cols);
    return rows + cols;
  endfunction

endpackage

// File: rtl/sa_tile_control_if.sv
// Host request/status and memory-port bundle of the tile controller.
interface sa_tile_control_if #(
  parameter int INPUT_HEIGHT  = 64,
  parameter int WEIGHT_HEIGHT = 64,
  parameter int OUTPUT_HEIGHT = 64,
  parameter int MAX_TILES     = 4
);
  logic                             i_start;
  logic [$clog2(MAX_TILES+1)-1:0]   i_num_tiles;
  logic [$clog2(INPUT_HEIGHT+1)-1:0] i_stream_len;
  logic                             o_busy;
  logic                             o_done;
  logic                             r_input_cenb;
  logic                             r_input_wenb;
  logic [$clog2(INPUT_HEIGHT)-1:0]  r_input_addr;
  logic                             r_weight_cenb;
  logic                             r_weight_wenb;
  logic [$clog2(WEIGHT_HEIGHT)-1:0] r_weight_addr;
  logic                             r_psum_cenb;
  logic [$clog2(OUTPUT_HEIGHT)-1:0] r_psum_addr;
  logic                             w_output_cenb;
  logic                             w_output_wenb;
  logic [$clog2(OUTPUT_HEIGHT)-1:0] w_output_addr;
  logic                             o_mode;
  logic                             o_load_psum;
  logic [$clog2(MAX_TILES)-1:0]     o_tile_idx;

  modport master (
    input  i_start, i_num_tiles, i_stream_len,
    output o_busy, o_done,
           r_input_cenb, r_input_wenb, r_input_addr,
           r_weight_cenb, r_weight_wenb, r_weight_addr,
           r_psum_cenb, r_psum_addr,
           w_output_cenb, w_output_wenb, w_output_addr,
           o_mode, o_load_psum, o_tile_idx
  );

  modport slave (
    output i_start, i_num_tiles, i_stream_len,
    input  o_busy, o_done,
           r_input_cenb, r_input_wenb, r_input_addr,
           r_weight_cenb, r_weight_wenb, r_weight_addr,
           r_psum_cenb, r_psum_addr,
           w_output_cenb, w_output_wenb, w_output_addr,
           o_mode, o_load_psum, o_tile_idx
  );
endinterface

// File: rtl/sa_tile_control_addr_gen.sv
// sa_addr_gen: clearable, enabled address counter wrapping to 0 at LIMIT.
module sa_addr_gen #(
  parameter int WIDTH = 6,
  parameter int LIMIT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] value
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    value <= '0;
    else if (clr)  value <= '0;
    else if (en)   value <= (value == WIDTH'(LIMIT - 1)) ? '0 : value + WIDTH'(1);
  end
endmodule

// File: rtl/sa_tile_control.sv
// Tile sequencer for a weight-stationary systolic array: per K-tile, preload
// weights then stream inputs and collect outputs. Optional SA_PERF_CNT_EN adds o_cycle_count.
module sa_tile_control
  import sa_pkg::*;
#(
  parameter int NUM_ROWS      = 4,
  parameter int NUM_COLS      = 4,
  parameter int INPUT_HEIGHT  = 64,
  parameter int WEIGHT_HEIGHT = 64,
  parameter int OUTPUT_HEIGHT = 64,
  parameter int MAX_TILES     = 4
) (
  input  logic clk,
  input  logic rst_n,
  sa_tile_control_if.master bus
`ifdef SA_PERF_CNT_EN
  ,
  output logic [31:0] o_cycle_count
`endif
);
  localparam int LAT   = sa_lat(NUM_ROWS, NUM_COLS);
  localparam int TW    = $clog2(MAX_TILES + 1);
  localparam int TIW   = $clog2(MAX_TILES);
  localparam int LW    = $clog2(INPUT_HEIGHT + 1);
  localparam int IAW   = $clog2(INPUT_HEIGHT);
  localparam int WAW   = $clog2(WEIGHT_HEIGHT);
  localparam int OAW   = $clog2(OUTPUT_HEIGHT);
  localparam int L_MAX = (INPUT_HEIGHT < OUTPUT_HEIGHT) ? INPUT_HEIGHT : OUTPUT_HEIGHT;
  localparam int CW    = $clog2(L_MAX + LAT + NUM_ROWS + 1);

  sa_ctrl_state_e state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [TW-1:0]  tiles, tiles_n;
  logic [LW-1:0]  len, len_n;
  logic [TIW-1:0] tile, tile_n, tile_o;

  logic           in_cenb, in_cenb_n, in_wenb, in_wenb_n;
  logic [IAW-1:0] in_addr, in_addr_n, in_gen;
  logic           w_cenb, w_cenb_n, w_wenb, w_wenb_n;
  logic [WAW-1:0] w_addr, w_addr_n, w_gen;
  logic           ps_cenb, ps_cenb_n;
  logic [OAW-1:0] ps_addr, ps_addr_n, ps_gen;
  logic           out_cenb, out_cenb_n, out_wenb, out_wenb_n;
  logic [OAW-1:0] out_addr, out_addr_n, out_gen;
  logic           mode, mode_n, load_psum, load_n;
  logic           busy, done, accept, st_clr, in_en, w_en, ps_en, out_en;

  logic          start_ok, in_win, ps_win, out_win, last_pre, last_stream, more_tiles;
  logic [CW-1:0] len_c;

  assign start_ok    = bus.i_start && (bus.i_num_tiles != '0) && (bus.i_stream_len != '0);
  assign len_c       = CW'(len);
  assign in_win      = cnt < len_c;
  // Psum for output j is fetched one cycle ahead of its write-back.
  assign ps_win      = (tile != '0) && (cnt >= CW'(LAT - 1)) && (cnt < len_c + CW'(LAT - 1));
  assign out_win     = (cnt >= CW'(LAT)) && (cnt < len_c + CW'(LAT));
  assign last_pre    = cnt == CW'(NUM_ROWS - 1);
  assign last_stream = cnt == len_c + CW'(LAT - 1);
  assign more_tiles  = (int'(tile) + 1) < int'(tiles);

  always_comb begin
    state_n = state; cnt_n = cnt; tiles_n = tiles; len_n = len; tile_n = tile;
    in_cenb_n = 1'b1; in_wenb_n = 1'b1; in_addr_n = '0;
    w_cenb_n = 1'b1;  w_wenb_n = 1'b1;  w_addr_n = '0;
    ps_cenb_n = 1'b1; ps_addr_n = '0;
    out_cenb_n = 1'b1; out_wenb_n = 1'b1; out_addr_n = '0;
    mode_n = 1'b0; load_n = 1'b0;
    busy = 1'b0; done = 1'b0; tile_o = tile;
    accept = 1'b0; st_clr = 1'b0; in_en = 1'b0; w_en = 1'b0; ps_en = 1'b0; out_en = 1'b0;
    case (state)
      IDLE: if (start_ok) begin
        accept  = 1'b1;
        state_n = PRELOAD;
        tiles_n = (int'(bus.i_num_tiles) > MAX_TILES) ? TW'(MAX_TILES) : bus.i_num_tiles;
        len_n   = (int'(bus.i_stream_len) > L_MAX) ? LW'(L_MAX) : bus.i_stream_len;
        cnt_n   = '0;
        tile_n  = '0;
      end
      PRELOAD: begin
        busy = 1'b1;
        w_cenb_n = 1'b0; w_addr_n = w_gen; w_en = 1'b1;
        st_clr = 1'b1;
        if (last_pre) begin state_n = STREAM; cnt_n = '0; end
        else cnt_n = cnt + CW'(1);
      end
      STREAM: begin
        busy = 1'b1; mode_n = 1'b1; load_n = (tile != '0);
        if (in_win)  begin in_cenb_n = 1'b0; in_addr_n = in_gen; in_en = 1'b1; end
        if (ps_win)  begin ps_cenb_n = 1'b0; ps_addr_n = ps_gen; ps_en = 1'b1; end
        if (out_win) begin out_cenb_n = 1'b0; out_wenb_n = 1'b0; out_addr_n = out_gen; out_en = 1'b1; end
        if (last_stream) begin
          cnt_n = '0;
          if (more_tiles) begin state_n = PRELOAD; tile_n = tile + TIW'(1); end
          else state_n = DONE;
        end else cnt_n = cnt + CW'(1);
      end
      DONE: begin busy = 1'b1; done = 1'b1; state_n = IDLE; end
      default: begin
        state_n = IDLE;
        in_cenb_n = 1'bx; in_wenb_n = 1'bx; in_addr_n = 'x;
        w_cenb_n = 1'bx;  w_wenb_n = 1'bx;  w_addr_n = 'x;
        ps_cenb_n = 1'bx; ps_addr_n = 'x;
        out_cenb_n = 1'bx; out_wenb_n = 1'bx; out_addr_n = 'x;
        mode_n = 1'bx; load_n = 1'bx; busy = 1'bx; done = 1'bx; tile_o = 'x;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE; cnt <= '0; tiles <= '0; len <= '0; tile <= '0;
      in_cenb <= 1'b1; in_wenb <= 1'b1; in_addr <= '0;
      w_cenb <= 1'b1;  w_wenb <= 1'b1;  w_addr <= '0;
      ps_cenb <= 1'b1; ps_addr <= '0;
      out_cenb <= 1'b1; out_wenb <= 1'b1; out_addr <= '0;
      mode <= 1'b0; load_psum <= 1'b0;
    end else begin
      state <= state_n; cnt <= cnt_n; tiles <= tiles_n; len <= len_n; tile <= tile_n;
      in_cenb <= in_cenb_n; in_wenb <= in_wenb_n; in_addr <= in_addr_n;
      w_cenb <= w_cenb_n;   w_wenb <= w_wenb_n;   w_addr <= w_addr_n;
      ps_cenb <= ps_cenb_n; ps_addr <= ps_addr_n;
      out_cenb <= out_cenb_n; out_wenb <= out_wenb_n; out_addr <= out_addr_n;
      mode <= mode_n; load_psum <= load_n;
    end
  end

  // Weight addresses run on across tiles; stream addresses restart every tile.
  sa_addr_gen #(.WIDTH(WAW), .LIMIT(WEIGHT_HEIGHT)) u_w_gen (
    .clk(clk), .rst_n(rst_n), .clr(accept), .en(w_en), .value(w_gen));
  sa_addr_gen #(.WIDTH(IAW), .LIMIT(INPUT_HEIGHT)) u_in_gen (
    .clk(clk), .rst_n(rst_n), .clr(st_clr), .en(in_en), .value(in_gen));
  sa_addr_gen #(.WIDTH(OAW), .LIMIT(OUTPUT_HEIGHT)) u_ps_gen (
    .clk(clk), .rst_n(rst_n), .clr(st_clr), .en(ps_en), .value(ps_gen));
  sa_addr_gen #(.WIDTH(OAW), .LIMIT(OUTPUT_HEIGHT)) u_out_gen (
    .clk(clk), .rst_n(rst_n), .clr(st_clr), .en(out_en), .value(out_gen));

  assign bus.o_busy        = busy;
  assign bus.o_done        = done;
  assign bus.o_tile_idx    = tile_o;
  assign bus.r_input_cenb  = in_cenb;
  assign bus.r_input_wenb  = in_wenb;
  assign bus.r_input_addr  = in_addr;
  assign bus.r_weight_cenb = w_cenb;
  assign bus.r_weight_wenb = w_wenb;
  assign bus.r_weight_addr = w_addr;
  assign bus.r_psum_cenb   = ps_cenb;
  assign bus.r_psum_addr   = ps_addr;
  assign bus.w_output_cenb = out_cenb;
  assign bus.w_output_wenb = out_wenb;
  assign bus.w_output_addr = out_addr;
  assign bus.o_mode        = mode;
  assign bus.o_load_psum   = load_psum;

`ifdef SA_PERF_CNT_EN
  logic [31:0] cyc_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         cyc_cnt <= '0;
    else if (accept)                    cyc_cnt <= '0;
    else if (busy && (cyc_cnt != '1))   cyc_cnt <= cyc_cnt + 32'd1;
  end
  assign o_cycle_count = cyc_cnt;
`endif

endmodule

// File: tb/tb_sa_tile_control.sv
// Bench for sa_tile_control: per-cycle schedule model plus directed and random jobs.
module tb_sa_tile_control;
  localparam int NR = 4, NC = 4, LAT = NR + NC, MAXT = 4, LMAX = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sa_tile_control_if #(.INPUT_HEIGHT(64), .WEIGHT_HEIGHT(64), .OUTPUT_HEIGHT(64), .MAX_TILES(MAXT)) bus();
`ifdef SA_PERF_CNT_EN
  logic [31:0] cyc_cnt;
`endif

  sa_tile_control #(.NUM_ROWS(NR), .NUM_COLS(NC), .INPUT_HEIGHT(64), .WEIGHT_HEIGHT(64),
                    .OUTPUT_HEIGHT(64), .MAX_TILES(MAXT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef SA_PERF_CNT_EN
    , .o_cycle_count(cyc_cnt)
`endif
  );

  // One entry per busy cycle: state-level outputs for that cycle and the
  // memory/mode requests that must show up on the following cycle.
  typedef struct {
    bit busy, done; int tile;
    bit wcen; int waddr; bit icen; int iaddr;
    bit pcen; int paddr; bit ocen; int oaddr;
    bit mode, load;
  } ent_t;

  ent_t q[$];
  ent_t prev;
  int unsigned mcyc;
  int vectors = 0, miscompares = 0;

  function automatic ent_t idle_ent();
    ent_t e;
    e.busy = 0; e.done = 0; e.tile = 0;
    e.wcen = 1; e.waddr = 0; e.icen = 1; e.iaddr = 0;
    e.pcen = 1; e.paddr = 0; e.ocen = 1; e.oaddr = 0;
    e.mode = 0; e.load = 0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic build(input int nt, input int sl);
    int nT, nL; ent_t e;
    nT = (nt > MAXT) ? MAXT : nt;
    nL = (sl > LMAX) ? LMAX : sl;
    for (int t = 0; t < nT; t++) begin
      for (int k = 0; k < NR; k++) begin
        e = idle_ent(); e.busy = 1; e.tile = t; e.wcen = 0; e.waddr = t * NR + k;
        q.push_back(e);
      end
      for (int c = 0; c < nL + LAT; c++) begin
        e = idle_ent(); e.busy = 1; e.tile = t; e.mode = 1; e.load = (t > 0);
        if (c < nL) begin e.icen = 0; e.iaddr = c; end
        if (t > 0 && c >= LAT - 1 && c - (LAT - 1) < nL) begin e.pcen = 0; e.paddr = c - (LAT - 1); end
        if (c >= LAT && c - LAT < nL) begin e.ocen = 0; e.oaddr = c - LAT; end
        q.push_back(e);
      end
    end
    e = idle_ent(); e.busy = 1; e.done = 1; e.tile = nT - 1;
    q.push_back(e);
  endtask

  task automatic model_reset();
    q.delete(); prev = idle_ent(); mcyc = 0;
  endtask

  task automatic model_step();
    bit was_idle;
    if (!rst_n) begin model_reset(); return; end
    was_idle = (q.size() == 0);
    if (!was_idle && mcyc != 32'hFFFF_FFFF) mcyc++;
    prev = was_idle ? idle_ent() : q.pop_front();
    if (was_idle && bus.i_start && bus.i_num_tiles != 0 && bus.i_stream_len != 0) begin
      build(int'(bus.i_num_tiles), int'(bus.i_stream_len));
      mcyc = 0;
    end
  endtask

  task automatic compare();
    ent_t h;
    h = (q.size() != 0) ? q[0] : idle_ent();
    chk("busy", 32'(bus.o_busy), 32'(h.busy));
    chk("done", 32'(bus.o_done), 32'(h.done));
    if (h.busy) chk("tile_idx", 32'(bus.o_tile_idx), h.tile);
    chk("w_cenb", 32'(bus.r_weight_cenb), 32'(prev.wcen));
    chk("w_wenb", 32'(bus.r_weight_wenb), 32'd1);
    chk("w_addr", 32'(bus.r_weight_addr), prev.waddr);
    chk("in_cenb", 32'(bus.r_input_cenb), 32'(prev.icen));
    chk("in_wenb", 32'(bus.r_input_wenb), 32'd1);
    chk("in_addr", 32'(bus.r_input_addr), prev.iaddr);
    chk("ps_cenb", 32'(bus.r_psum_cenb), 32'(prev.pcen));
    chk("ps_addr", 32'(bus.r_psum_addr), prev.paddr);
    chk("out_cenb", 32'(bus.w_output_cenb), 32'(prev.ocen));
    chk("out_wenb", 32'(bus.w_output_wenb), 32'(prev.ocen));
    chk("out_addr", 32'(bus.w_output_addr), prev.oaddr);
    chk("mode", 32'(bus.o_mode), 32'(prev.mode));
    chk("load_psum", 32'(bus.o_load_psum), 32'(prev.load));
`ifdef SA_PERF_CNT_EN
    chk("cycle_count", cyc_cnt, mcyc);
`endif
  endtask

  // Advance one clock: model sees the edge, outputs are checked mid-cycle.
  task automatic cyc();
    @(posedge clk); model_step();
    @(negedge clk); compare();
  endtask

  task automatic run_job(input int nt, input int sl, input int exp_busy, input bit poke);
    int nb, dones, first_rd, first_wr;
    nb = 0; dones = 0; first_rd = -1; first_wr = -1;
    bus.i_start = 1'b1; bus.i_num_tiles = 3'(nt); bus.i_stream_len = 7'(sl);
    cyc();
    bus.i_start = 1'b0;
    while (bus.o_busy === 1'b1 && nb < 2000) begin
      nb++;
      if (bus.o_done === 1'b1) dones++;
      if (first_rd < 0 && bus.r_input_cenb === 1'b0) first_rd = nb;
      if (first_wr < 0 && bus.w_output_cenb === 1'b0) first_wr = nb;
      bus.i_start = poke && (nb == 10);
      bus.i_num_tiles = 3'd1; bus.i_stream_len = 7'd1;
      cyc();
    end
    bus.i_start = 1'b0;
    chk("busy_cycles", nb, exp_busy);
    chk("done_pulses", dones, 1);
    chk("read_to_write", first_wr - first_rd, LAT);
    repeat (2) cyc();
    chk("idle_after_job", 32'(bus.o_busy), 32'd0);
  endtask

  initial begin
    bus.i_start = 1'b0; bus.i_num_tiles = '0; bus.i_stream_len = '0;
    model_reset();
    repeat (3) cyc();
    chk("reset_busy", 32'(bus.o_busy), 32'd0);
    chk("reset_done", 32'(bus.o_done), 32'd0);
    chk("reset_mode", 32'(bus.o_mode), 32'd0);
    chk("reset_cenb", {29'd0, bus.r_input_cenb, bus.r_weight_cenb, bus.w_output_cenb}, 32'd7);
    rst_n = 1'b1;
    cyc();

    run_job(1, 4, 17, 1'b0);
    run_job(3, 2, 43, 1'b0);

    bus.i_start = 1'b1; bus.i_num_tiles = 3'd0; bus.i_stream_len = 7'd3;
    repeat (2) cyc();
    chk("ignore_t0", 32'(bus.o_busy), 32'd0);
    bus.i_num_tiles = 3'd2; bus.i_stream_len = 7'd0;
    repeat (2) cyc();
    chk("ignore_l0", 32'(bus.o_busy), 32'd0);
    bus.i_start = 1'b0;
    cyc();

    run_job(1, 4, 17, 1'b1);
    run_job(7, 1, 53, 1'b0);
    run_job(1, 100, 77, 1'b0);

    // Abort during tile 1 streaming (busy cycles 19..28 of a T=3, L=2 job).
    bus.i_start = 1'b1; bus.i_num_tiles = 3'd3; bus.i_stream_len = 7'd2;
    cyc();
    bus.i_start = 1'b0;
    repeat (19) cyc();
    chk("pre_abort_tile", 32'(bus.o_tile_idx), 32'd1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("abort_busy", 32'(bus.o_busy), 32'd0);
    chk("abort_done", 32'(bus.o_done), 32'd0);
    chk("abort_cenb", {28'd0, bus.r_input_cenb, bus.r_weight_cenb, bus.r_psum_cenb, bus.w_output_cenb}, 32'd15);
    chk("abort_mode", {30'd0, bus.o_mode, bus.o_load_psum}, 32'd0);
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    run_job(1, 1, 14, 1'b0);

`ifdef SA_PERF_CNT_EN
    run_job(2, 4, 33, 1'b0);
    repeat (3) cyc();
    chk("cycle_count_hold", cyc_cnt, 32'd33);
`endif

    repeat (3000) begin
      bus.i_start = ($urandom_range(0, 5) == 0);
      bus.i_num_tiles = 3'($urandom_range(0, 7));
      bus.i_stream_len = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127))
                                                     : 7'($urandom_range(0, 6));
      cyc();
    end
    bus.i_start = 1'b0;
    for (int g = 0; g < 400 && bus.o_busy === 1'b1; g++) cyc();
    chk("drain_idle", 32'(bus.o_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
